// File: rtl/note_playback_if.sv
// note_playback_if: note selection, sample-tick, memory-read and sample-output signals of the playback controller
interface note_playback_if #(parameter int ADDR_W = 24);
  logic [ADDR_W-1:0] note_addr;
  logic              sample_tick;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;
  logic [7:0]        sample_out;
  logic              sample_valid;
  logic              overrun;
  modport master (
    output note_addr, sample_tick, mem_ack, mem_data,
    input  mem_req, mem_addr, sample_out, sample_valid, overrun
  );
  modport slave (
    input  note_addr, sample_tick, mem_ack, mem_data,
    output mem_req, mem_addr, sample_out, sample_valid, overrun
  );
endinterface

// File: rtl/note_playback_ctrl.sv
// note_playback_ctrl: fetches one clip sample per audio tick from memory, looping over CLIP_LEN samples per note
module note_playback_ctrl #(
  parameter int CLIP_LEN = 11264,
  parameter int ADDR_W   = 24
) (
  input logic            clk,
  input logic            rst,
  note_playback_if.slave bus
);
  localparam int OW = CLIP_LEN > 1 ? $clog2(CLIP_LEN) : 1;
  typedef enum logic {IDLE, FETCH} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] base, base_n, addr, addr_n;
  logic [OW-1:0]     offset, offset_n;
  logic              req, req_n, valid, valid_n, ovr, ovr_n;
  logic [7:0]        out, out_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      base   <= '0;
      offset <= '0;
      req    <= 1'b0;
      addr   <= '0;
      out    <= '0;
      valid  <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      state  <= state_n;
      base   <= base_n;
      offset <= offset_n;
      req    <= req_n;
      addr   <= addr_n;
      out    <= out_n;
      valid  <= valid_n;
      ovr    <= ovr_n;
    end
  end
  // A new note and a tick in the same IDLE cycle fetch from the new base at offset 0
  always_comb begin
    state_n  = state;
    base_n   = base;
    offset_n = offset;
    req_n    = req;
    addr_n   = addr;
    out_n    = out;
    valid_n  = 1'b0;
    ovr_n    = ovr;
    if (state == IDLE) begin
      if (bus.note_addr != base) begin
        base_n   = bus.note_addr;
        offset_n = '0;
      end
      if (bus.sample_tick) begin
        state_n = FETCH;
        req_n   = 1'b1;
        addr_n  = base_n + ADDR_W'(offset_n);
      end
    end else begin
      ovr_n = ovr | bus.sample_tick;
      if (bus.mem_ack) begin
        state_n  = IDLE;
        req_n    = 1'b0;
        out_n    = bus.mem_data;
        valid_n  = 1'b1;
        offset_n = offset == OW'(CLIP_LEN - 1) ? '0 : offset + 1'b1;
      end
    end
  end
  assign bus.mem_req      = req;
  assign bus.mem_addr     = addr;
  assign bus.sample_out   = out;
  assign bus.sample_valid = valid;
  assign bus.overrun      = ovr;
endmodule

// File: tb/tb_note_playback_ctrl.sv
// tb_note_playback_ctrl: randomized self-checking bench with a clip-position reference model
module tb_note_playback_ctrl;
  localparam int CLIP_LEN = 11264;
  localparam int ADDR_W   = 24;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  note_playback_if #(.ADDR_W(ADDR_W)) bus();
  note_playback_ctrl #(.CLIP_LEN(CLIP_LEN), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  int m_base = 0;
  int m_off = 0;
  function automatic logic [ADDR_W-1:0] model_addr();
    if (int'(bus.note_addr) != m_base) begin
      m_base = int'(bus.note_addr);
      m_off  = 0;
    end
    return ADDR_W'(m_base + m_off);
  endfunction
  function automatic void model_ack();
    m_off = (m_off + 1) % CLIP_LEN;
  endfunction
  task automatic fetch(input logic [7:0] data, input int delay, input bit mid, input logic [ADDR_W-1:0] mid_note,
                       output logic [ADDR_W-1:0] addr, output bit timeout, output bit stable,
                       output logic v1, output logic [7:0] o1, output logic r1, output logic v2);
    int k = 0;
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    while (bus.mem_req !== 1'b1 && k < 4) begin
      @(negedge clk);
      k++;
    end
    timeout = bus.mem_req !== 1'b1;
    addr    = bus.mem_addr;
    stable  = 1'b1;
    if (mid) bus.note_addr = mid_note;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (bus.mem_addr !== addr || bus.mem_req !== 1'b1) stable = 1'b0;
    end
    bus.mem_ack  = 1'b1;
    bus.mem_data = data;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    v1 = bus.sample_valid;
    o1 = bus.sample_out;
    r1 = bus.mem_req;
    @(negedge clk);
    v2 = bus.sample_valid;
  endtask
  logic [ADDR_W-1:0] a, e;
  bit to, st;
  logic v1, r1, v2;
  logic [7:0] o1;
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bus.mem_req, bus.mem_addr, bus.sample_out, bus.sample_valid, bus.overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: outputs=%h required 0", {bus.mem_req, bus.mem_addr, bus.sample_out, bus.sample_valid, bus.overrun});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bus.mem_req, bus.sample_valid, bus.overrun} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release: req/valid/ovr=%b required 000", {bus.mem_req, bus.sample_valid, bus.overrun});
    end
  endtask
  task automatic test_basic();
    bus.note_addr = 24'h002C00;
    @(negedge clk);
    e = model_addr();
    fetch(8'h5A, 3, 1'b0, '0, a, to, st, v1, o1, r1, v2);
    model_ack();
    n_chk++;
    if (to || a !== 24'h002C00 || e !== 24'h002C00 || !st) begin
      n_fail++;
      $display("FAIL basic_addr: addr=%h timeout=%0d stable=%0d required 002c00", a, to, st);
    end
    n_chk++;
    if ({v1, o1, r1, v2} !== {1'b1, 8'h5A, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_data: valid=%b out=%h req=%b valid_next=%b required 1 5a 0 0", v1, o1, r1, v2);
    end
    e = model_addr();
    fetch(8'hC3, 1, 1'b0, '0, a, to, st, v1, o1, r1, v2);
    model_ack();
    n_chk++;
    if (to || a !== e || a !== 24'h002C01) begin
      n_fail++;
      $display("FAIL basic_offset: addr=%h required 002c01", a);
    end
    @(negedge clk);
    n_chk++;
    if (bus.sample_out !== 8'hC3 || bus.sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: out=%h valid=%b required c3 0", bus.sample_out, bus.sample_valid);
    end
  endtask
  task automatic test_wrap();
    int bad = 0;
    while (m_off != CLIP_LEN - 1) begin
      e = model_addr();
      fetch(8'(m_off), 0, 1'b0, '0, a, to, st, v1, o1, r1, v2);
      model_ack();
      if (to || a !== e || v1 !== 1'b1 || o1 !== 8'(m_off - 1)) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wrap_sweep: bad fetches=%0d required 0", bad);
    end
    e = model_addr();
    fetch(8'h11, 0, 1'b0, '0, a, to, st, v1, o1, r1, v2);
    model_ack();
    n_chk++;
    if (to || a !== e || a !== 24'h002C00 + 24'd11263) begin
      n_fail++;
      $display("FAIL wrap_last: addr=%h required %h", a, 24'h002C00 + 24'd11263);
    end
    e = model_addr();
    fetch(8'h22, 0, 1'b0, '0, a, to, st, v1, o1, r1, v2);
    model_ack();
    n_chk++;
    if (to || a !== e || a !== 24'h002C00) begin
      n_fail++;
      $display("FAIL wrap_first: addr=%h required 002c00", a);
    end
  endtask
  task automatic test_note_change();
    e = model_addr();
    fetch(8'h33, 2, 1'b1, 24'h005800, a, to, st, v1, o1, r1, v2);
    model_ack();
    n_chk++;
    if (to || a !== e || a !== 24'h002C01 || !st || v1 !== 1'b1 || o1 !== 8'h33) begin
      n_fail++;
      $display("FAIL note_change_old: addr=%h stable=%0d valid=%b out=%h required 002c01 1 1 33", a, st, v1, o1);
    end
    e = model_addr();
    fetch(8'h44, 0, 1'b0, '0, a, to, st, v1, o1, r1, v2);
    model_ack();
    n_chk++;
    if (to || a !== e || a !== 24'h005800) begin
      n_fail++;
      $display("FAIL note_change_new: addr=%h required 005800", a);
    end
  endtask
  task automatic test_coincident();
    bus.note_addr = 24'h0ABCDE;
    e = model_addr();
    fetch(8'h55, 1, 1'b0, '0, a, to, st, v1, o1, r1, v2);
    model_ack();
    n_chk++;
    if (to || a !== e || a !== 24'h0ABCDE) begin
      n_fail++;
      $display("FAIL coincident: addr=%h required 0abcde", a);
    end
  endtask
  task automatic test_overrun();
    int nv = 0;
    n_chk++;
    if (bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: overrun=%b required 0", bus.overrun);
    end
    e = model_addr();
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    @(negedge clk);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.overrun !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_addr !== e) begin
      n_fail++;
      $display("FAIL overrun_set: overrun=%b req=%b addr=%h required 1 1 %h", bus.overrun, bus.mem_req, bus.mem_addr, e);
    end
    bus.mem_ack     = 1'b1;
    bus.mem_data    = 8'h66;
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.mem_ack     = 1'b0;
    bus.sample_tick = 1'b0;
    model_ack();
    for (int i = 0; i < 6; i++) begin
      nv += int'(bus.sample_valid);
      @(negedge clk);
    end
    n_chk++;
    if (nv != 1 || bus.overrun !== 1'b1 || bus.mem_req !== 1'b0 || bus.sample_out !== 8'h66) begin
      n_fail++;
      $display("FAIL overrun_single: valids=%0d overrun=%b req=%b out=%h required 1 1 0 66", nv, bus.overrun, bus.mem_req, bus.sample_out);
    end
  endtask
  task automatic test_random();
    int bad = 0;
    for (int it = 0; it < 300; it++) begin
      int sel = $urandom_range(0, 3);
      logic [ADDR_W-1:0] nn = ADDR_W'($urandom);
      logic [7:0] d = 8'($urandom);
      if (sel == 0) bus.note_addr = nn;
      e = model_addr();
      fetch(d, $urandom_range(0, 3), sel == 1, nn, a, to, st, v1, o1, r1, v2);
      model_ack();
      if (to || a !== e || !st || v1 !== 1'b1 || o1 !== d || r1 !== 1'b0 || v2 !== 1'b0) begin
        bad++;
        if (bad < 5) $display("FAIL random_fetch: it=%0d addr=%h valid=%b out=%h required %h 1 %h", it, a, v1, o1, e, d);
      end
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL random_total: bad fetches=%0d required 0", bad);
    end
  endtask
  task automatic test_async_reset();
    int k = 0;
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    while (bus.mem_req !== 1'b1 && k < 4) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (bus.mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: req=%b required 1", bus.mem_req);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({bus.mem_req, bus.mem_addr, bus.sample_out, bus.sample_valid, bus.overrun} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: outputs=%h required 0", {bus.mem_req, bus.mem_addr, bus.sample_out, bus.sample_valid, bus.overrun});
    end
    @(negedge clk);
    rst = 1'b0;
    m_base = 0;
    m_off  = 0;
    bus.mem_ack  = 1'b1;
    bus.mem_data = 8'h77;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    n_chk++;
    if (bus.sample_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.sample_out !== 8'h00) begin
      n_fail++;
      $display("FAIL async_late_ack: valid=%b req=%b out=%h required 0 0 00", bus.sample_valid, bus.mem_req, bus.sample_out);
    end
    e = model_addr();
    fetch(8'h88, 0, 1'b0, '0, a, to, st, v1, o1, r1, v2);
    model_ack();
    n_chk++;
    if (to || a !== e || a !== bus.note_addr || v1 !== 1'b1 || o1 !== 8'h88) begin
      n_fail++;
      $display("FAIL async_relatch: addr=%h valid=%b out=%h required %h 1 88", a, v1, o1, e);
    end
  endtask
  initial begin
    bus.note_addr   = '0;
    bus.sample_tick = 1'b0;
    bus.mem_ack     = 1'b0;
    bus.mem_data    = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_note_change();
    test_coincident();
    test_overrun();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
